// File: rtl/reg_file_sb.sv
// reg_file_sb -- integer register file with busy scoreboard and clear engine.
//
// Purpose:
//   NREGS x XLEN register file for the Tiny RISC-V core. It has two
//   combinational read ports (rs1/rs2) and one combinational debug read port.
//   Writes come from the core writeback port or from a handshaked debug write
//   port. A per-register busy scoreboard is set at issue and cleared at
//   writeback. A two-state engine (IDLE/CLEAR) zeroes the whole file over
//   NREGS-1 cycles without a reset. Register x0 is hard-wired to zero and is
//   never busy.
//
// Optional feature (macro REG_FILE_BYPASS_EN):
//   When defined, a core write in IDLE is forwarded to rs1/rs2 in the same
//   cycle (data = write_data, busy = 0). The debug read port is never bypassed.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   rs1, rs2                   read addresses
//   read_data1, read_data2     read data (combinational)
//   busy1, busy2               scoreboard bits for rs1/rs2 (combinational)
//   rd, write_data, reg_write  core writeback port
//   issue_valid, issue_rd      scoreboard set port
//   debug_reg_addr             debug read/write address
//   debug_reg_data             debug read data (combinational)
//   debug_wr_valid/_data/_ready  debug write handshake
//   clear_req, clear_busy      clear engine start / active flag
//
// Debug write handshake: the requester raises debug_wr_valid and holds
// debug_wr_data and debug_reg_addr stable until debug_wr_ready is high. The
// write is accepted on the rising edge where valid && ready are both high.
// ready is low whenever the core writes a nonzero rd (core write has
// priority) and for the whole time the clear engine is active.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            busy1,
  output logic            busy2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            reg_write,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   debug_reg_addr,
  output logic [XLEN-1:0] debug_reg_data,
  input  logic            debug_wr_valid,
  input  logic [XLEN-1:0] debug_wr_data,
  output logic            debug_wr_ready,
  input  logic            clear_req,
  output logic            clear_busy
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_CLEAR  = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [0:0]      r_state;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic w_idle;
  logic w_core_wr;
  logic w_issue;
  logic w_dbg_wr;

  assign w_idle    = (r_state == S_IDLE);
  assign w_core_wr = w_idle && reg_write && (rd != '0);
  assign w_issue   = w_idle && issue_valid && (issue_rd != '0);

  // Reset forces the state to IDLE, so during reset ready reduces to
  // !(reg_write && rd != 0) without any extra term.
  assign debug_wr_ready = w_idle && !(reg_write && (rd != '0));
  assign w_dbg_wr       = debug_wr_valid && debug_wr_ready && (debug_reg_addr != '0);

  assign clear_busy = (r_state == S_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == S_IDLE) begin
      // Core write and debug write never collide: ready excludes core writes.
      if (w_core_wr) begin
        r_regs[rd] <= write_data;
        r_busy[rd] <= 1'b0;
      end
      if (w_dbg_wr) begin
        r_regs[debug_reg_addr] <= debug_wr_data;
      end
      // Placed after the writeback clear so that a same-register issue wins.
      if (w_issue) begin
        r_busy[issue_rd] <= 1'b1;
      end
      if (clear_req) begin
        r_state <= S_CLEAR;
        r_idx   <= AW'(1);
      end
    end else begin
      // x0 is already zero, so the sweep starts at 1 and ends at NREGS-1.
      r_regs[r_idx] <= '0;
      r_busy[r_idx] <= 1'b0;
      r_idx         <= r_idx + AW'(1);
      if (r_idx == LAST_IDX) begin
        r_state <= S_IDLE;
      end
    end
  end

  always_comb begin
    read_data1     = (rs1 == '0) ? '0 : r_regs[rs1];
    read_data2     = (rs2 == '0) ? '0 : r_regs[rs2];
    busy1          = r_busy[rs1];
    busy2          = r_busy[rs2];
    debug_reg_data = (debug_reg_addr == '0) ? '0 : r_regs[debug_reg_addr];
`ifdef REG_FILE_BYPASS_EN
    // w_core_wr implies rd != 0, so x0 reads are never forwarded.
    if (w_core_wr && (rs1 == rd)) begin
      read_data1 = write_data;
      busy1      = 1'b0;
    end
    if (w_core_wr && (rs2 == rd)) begin
      read_data2 = write_data;
      busy2      = 1'b0;
    end
`else
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb -- self-checking bench for reg_file_sb (XLEN=32, NREGS=32).
// A behavioural model (arrays plus a clearing flag) tracks the expected
// register contents, busy bits and clear progress.
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk, rst;
  logic [AW-1:0]   rs1, rs2, rd, issue_rd, debug_reg_addr;
  logic [XLEN-1:0] read_data1, read_data2, write_data, debug_reg_data, debug_wr_data;
  logic            busy1, busy2, reg_write, issue_valid;
  logic            debug_wr_valid, debug_wr_ready, clear_req, clear_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_clearing;
  int              m_next;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2),
    .read_data1(read_data1), .read_data2(read_data2),
    .busy1(busy1), .busy2(busy2),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .debug_reg_addr(debug_reg_addr), .debug_reg_data(debug_reg_data),
    .debug_wr_valid(debug_wr_valid), .debug_wr_data(debug_wr_data),
    .debug_wr_ready(debug_wr_ready),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_clearing = 1'b0;
    m_next     = 0;
  endfunction

  // Applies the effect of one rising edge given the current inputs.
  function automatic void model_step();
    bit core;
    core = reg_write && (rd != '0);
    if (!m_clearing) begin
      if (core) begin
        m_regs[rd] = write_data;
        m_busy[rd] = 1'b0;
      end
      if (debug_wr_valid && !core && (debug_reg_addr != '0))
        m_regs[debug_reg_addr] = debug_wr_data;
      if (issue_valid && (issue_rd != '0))
        m_busy[issue_rd] = 1'b1;
      if (clear_req) begin
        m_clearing = 1'b1;
        m_next     = 1;
      end
    end else begin
      m_regs[m_next] = '0;
      m_busy[m_next] = 1'b0;
      m_next++;
      if (m_next == NREGS) m_clearing = 1'b0;
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    exp_read = m_regs[a];
`ifdef REG_FILE_BYPASS_EN
    if (!m_clearing && reg_write && (rd != '0) && (a == rd)) exp_read = write_data;
`endif
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    exp_busy = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
    if (!m_clearing && reg_write && (rd != '0) && (a == rd)) exp_busy = 1'b0;
`endif
  endfunction

  function automatic logic exp_ready();
    exp_ready = !m_clearing && !(reg_write && (rd != '0));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0; write_data = '0; reg_write = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; debug_reg_addr = '0;
    debug_wr_valid = 1'b0; debug_wr_data = '0; clear_req = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rs1 = 5'd5; rs2 = 5'd31; debug_reg_addr = 5'd7;
    reg_write = 1'b1; rd = 5'd5; write_data = 32'h1111_2222;
    #1;
    n_checks++; if (read_data1 !== '0) begin n_fail++; $display("FAIL reset_rd1 got=%h exp=0", read_data1); end
    n_checks++; if (read_data2 !== '0) begin n_fail++; $display("FAIL reset_rd2 got=%h exp=0", read_data2); end
    n_checks++; if (debug_reg_data !== '0) begin n_fail++; $display("FAIL reset_dbg got=%h exp=0", debug_reg_data); end
    n_checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b%b exp=00", busy1, busy2); end
    n_checks++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clear_busy got=%b exp=0", clear_busy); end
    n_checks++; if (debug_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_wr got=%b exp=0", debug_wr_ready); end
    rd = 5'd0;
    #1;
    n_checks++; if (debug_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_x0 got=%b exp=1", debug_wr_ready); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    idle_inputs();
    reg_write = 1'b1; rd = 5'd5; write_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs(); rs1 = 5'd5; #1;
    n_checks++; if (read_data1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_x5 got=%h exp=deadbeef", read_data1); end
    reg_write = 1'b1; rd = 5'd0; write_data = 32'h1234;
    tick();
    idle_inputs(); rs2 = 5'd0; #1;
    n_checks++; if (read_data2 !== '0) begin n_fail++; $display("FAIL wr_x0 got=%h exp=0", read_data2); end
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      reg_write = 1'b1; rd = AW'($urandom); write_data = $urandom;
      rs1 = AW'($urandom); rs2 = rd;
      #1;
      n_checks++; if (read_data1 !== exp_read(rs1)) begin n_fail++; $display("FAIL rand_rd1 a=%0d got=%h exp=%h", rs1, read_data1, exp_read(rs1)); end
      n_checks++; if (read_data2 !== exp_read(rs2)) begin n_fail++; $display("FAIL rand_rd2 a=%0d got=%h exp=%h", rs2, read_data2, exp_read(rs2)); end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    reg_write = 1'b1; rd = 5'd4; write_data = 32'h66;
    tick();
    reg_write = 1'b1; rd = 5'd4; write_data = 32'h77; rs1 = 5'd4;
    #1;
`ifdef REG_FILE_BYPASS_EN
    n_checks++; if (read_data1 !== 32'h77) begin n_fail++; $display("FAIL bypass_same got=%h exp=77", read_data1); end
`else
    n_checks++; if (read_data1 !== 32'h66) begin n_fail++; $display("FAIL nobypass_same got=%h exp=66", read_data1); end
`endif
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got=%b exp=0", busy1); end
    tick();
    idle_inputs(); rs1 = 5'd4; #1;
    n_checks++; if (read_data1 !== 32'h77) begin n_fail++; $display("FAIL bypass_next got=%h exp=77", read_data1); end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs(); rs1 = 5'd7; #1;
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_issue got=%b exp=1", busy1); end
    reg_write = 1'b1; rd = 5'd7; write_data = 32'h55;
    tick();
    idle_inputs(); rs1 = 5'd7; #1;
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_wb_busy got=%b exp=0", busy1); end
    n_checks++; if (read_data1 !== 32'h55) begin n_fail++; $display("FAIL sb_wb_data got=%h exp=55", read_data1); end
    issue_valid = 1'b1; issue_rd = 5'd7;
    reg_write = 1'b1; rd = 5'd7; write_data = 32'h66;
    tick();
    idle_inputs(); rs2 = 5'd7; #1;
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got=%b exp=1", busy2); end
    n_checks++; if (read_data2 !== 32'h66) begin n_fail++; $display("FAIL sb_set_wins_data got=%h exp=66", read_data2); end
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    idle_inputs(); rs1 = 5'd0; #1;
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_x0 got=%b exp=0", busy1); end
  endtask

  task automatic test_debug_write();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle_inputs();
    debug_wr_valid = 1'b1; debug_reg_addr = 5'd3; debug_wr_data = 32'hA5A5_A5A5;
    reg_write = 1'b1; rd = 5'd9; write_data = 32'h99;
    #1;
    n_checks++; if (debug_wr_ready !== 1'b0) begin n_fail++; $display("FAIL dbg_blocked got=%b exp=0", debug_wr_ready); end
    tick();
    reg_write = 1'b0; #1;
    n_checks++; if (debug_wr_ready !== 1'b1) begin n_fail++; $display("FAIL dbg_ready got=%b exp=1", debug_wr_ready); end
    tick();
    idle_inputs(); debug_reg_addr = 5'd3; rs1 = 5'd3; rs2 = 5'd9; #1;
    n_checks++; if (debug_reg_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL dbg_data got=%h exp=a5a5a5a5", debug_reg_data); end
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL dbg_busy_kept got=%b exp=1", busy1); end
    n_checks++; if (read_data2 !== 32'h99) begin n_fail++; $display("FAIL dbg_core_wr got=%h exp=99", read_data2); end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 1; i < NREGS; i++) begin
      idle_inputs(); reg_write = 1'b1; rd = AW'(i); write_data = $urandom | 32'h1;
      tick();
    end
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd9; tick();
    idle_inputs(); clear_req = 1'b1; tick();
    cnt = 0;
    for (int c = 0; c < NREGS + 4; c++) begin
      idle_inputs();
      if (m_clearing) begin
        reg_write = 1'($urandom); rd = AW'($urandom); write_data = $urandom;
        issue_valid = 1'($urandom); issue_rd = AW'($urandom);
        clear_req = 1'($urandom);
        debug_wr_valid = 1'($urandom); debug_wr_data = $urandom;
      end
      rs1 = AW'($urandom); debug_reg_addr = AW'($urandom);
      #1;
      n_checks++; if (clear_busy !== m_clearing) begin n_fail++; $display("FAIL clr_busy c=%0d got=%b exp=%b", c, clear_busy, m_clearing); end
      n_checks++; if (read_data1 !== exp_read(rs1)) begin n_fail++; $display("FAIL clr_partial a=%0d got=%h exp=%h", rs1, read_data1, exp_read(rs1)); end
      n_checks++; if (debug_reg_data !== m_regs[debug_reg_addr]) begin n_fail++; $display("FAIL clr_dbg a=%0d got=%h exp=%h", debug_reg_addr, debug_reg_data, m_regs[debug_reg_addr]); end
      n_checks++; if (debug_wr_ready !== exp_ready()) begin n_fail++; $display("FAIL clr_ready got=%b exp=%b", debug_wr_ready, exp_ready()); end
      if (clear_busy === 1'b1) cnt++;
      tick();
    end
    n_checks++; if (cnt != NREGS - 1) begin n_fail++; $display("FAIL clr_cycles got=%0d exp=%0d", cnt, NREGS - 1); end
    for (int a = 0; a < NREGS; a++) begin
      idle_inputs(); rs1 = AW'(a); rs2 = AW'(a); #1;
      n_checks++; if (read_data1 !== '0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL clr_after a=%0d got=%h/%b exp=0/0", a, read_data1, busy2); end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 1; i < 6; i++) begin
      idle_inputs(); reg_write = 1'b1; rd = AW'(i); write_data = 32'hF0 + i;
      tick();
    end
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd20; tick();
    idle_inputs(); clear_req = 1'b1; tick();
    idle_inputs(); repeat (3) tick();
    rs1 = 5'd5; rs2 = 5'd20;
    #1;
    n_checks++; if (clear_busy !== 1'b1 || read_data1 !== 32'hF5) begin n_fail++; $display("FAIL midclr_pre got=%b/%h exp=1/f5", clear_busy, read_data1); end
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_abort got=%b exp=0", clear_busy); end
    n_checks++; if (read_data1 !== '0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL midclr_state got=%h/%b exp=0/0", read_data1, busy2); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    #1;
    n_checks++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_after got=%b exp=0", clear_busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rs1 = AW'($urandom); rs2 = AW'($urandom);
      reg_write = 1'($urandom); rd = AW'($urandom); write_data = $urandom;
      issue_valid = 1'($urandom); issue_rd = AW'($urandom);
      debug_wr_valid = 1'($urandom); debug_reg_addr = AW'($urandom); debug_wr_data = $urandom;
      clear_req = ($urandom_range(0, 59) == 0);
      #1;
      n_checks++; if (read_data1 !== exp_read(rs1)) begin n_fail++; $display("FAIL rnd_rd1 c=%0d got=%h exp=%h", c, read_data1, exp_read(rs1)); end
      n_checks++; if (read_data2 !== exp_read(rs2)) begin n_fail++; $display("FAIL rnd_rd2 c=%0d got=%h exp=%h", c, read_data2, exp_read(rs2)); end
      n_checks++; if (busy1 !== exp_busy(rs1)) begin n_fail++; $display("FAIL rnd_busy1 c=%0d got=%b exp=%b", c, busy1, exp_busy(rs1)); end
      n_checks++; if (busy2 !== exp_busy(rs2)) begin n_fail++; $display("FAIL rnd_busy2 c=%0d got=%b exp=%b", c, busy2, exp_busy(rs2)); end
      n_checks++; if (debug_reg_data !== m_regs[debug_reg_addr]) begin n_fail++; $display("FAIL rnd_dbg c=%0d got=%h exp=%h", c, debug_reg_data, m_regs[debug_reg_addr]); end
      n_checks++; if (debug_wr_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, debug_wr_ready, exp_ready()); end
      n_checks++; if (clear_busy !== m_clearing) begin n_fail++; $display("FAIL rnd_clr c=%0d got=%b exp=%b", c, clear_busy, m_clearing); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_debug_write();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
